// File: rtl/sr_cond_pkg.sv
// Shared types and defaults for the set/reset input conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sr_cond_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PULSE_CYCLES    = 1;

  // Counter widths cover the legal parameter ranges (2..255 and 1..15).
  localparam int DB_CNT_W    = 8;
  localparam int PULSE_CNT_W = 4;
  localparam int EVT_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_PULSE = 2'd1,
    CLR_PULSE = 2'd2
  } state_t;

endpackage

// File: rtl/sr_input_conditioner_if.sv
// Button-side and flip-flop-side signals of the conditioner.
// Latency: n/a (wires only).
// Backpressure: none; the downstream SR flip-flop always accepts s/r.
// Signals: set_btn/clr_btn raw requests, s/r pulses, busy status,
//          event_count only when SR_EVENT_CNT_EN is defined.
interface sr_input_conditioner_if;
  import sr_cond_pkg::*;

  logic set_btn;
  logic clr_btn;
  logic s;
  logic r;
  logic busy;
`ifdef SR_EVENT_CNT_EN
  logic [EVT_CNT_W-1:0] event_count;
`endif

`ifdef SR_EVENT_CNT_EN
  // master: the environment driving the buttons
  modport master (output set_btn, output clr_btn,
                  input s, input r, input busy, input event_count);
  // slave: the conditioner itself
  modport slave  (input set_btn, input clr_btn,
                  output s, output r, output busy, output event_count);
`else
  modport master (output set_btn, output clr_btn,
                  input s, input r, input busy);
  modport slave  (input set_btn, input clr_btn,
                  output s, output r, output busy);
`endif

endinterface

// File: rtl/sr_debounce.sv
// One channel: 2-flop synchronizer, stability counter, debounced level, rise strobe.
// Latency: level changes DEBOUNCE_CYCLES+2 edges after raw input settles; rise one-cycle registered strobe.
// Backpressure: none; strobe is fire-and-forget, the consumer must latch it.
// Ports: clock, reset_n, raw (async input), level (debounced), rise (1-cycle pulse on 0->1).
module sr_debounce
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  // The toggle fires on the edge that would make the count equal DEBOUNCE_CYCLES,
  // so the comparison is against one less.
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1;
  logic                sync2;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
        rise  <= ~level;  // only a 0->1 toggle produces a strobe
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sr_input_conditioner.sv
// Debounces set/clear pushbuttons and issues mutually exclusive s/r pulses to an SR flip-flop.
// Latency: s rises 2+DEBOUNCE_CYCLES+1 edges after the first edge sampling a stable press.
// Backpressure: one pending request per channel; repeat presses while pending are merged.
// Ports: clock, reset_n (async active-low), bus (slave modport: set_btn, clr_btn, s, r, busy).
// Optional: define SR_EVENT_CNT_EN to add bus.event_count, a saturating pulse counter.
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset_n,
  sr_input_conditioner_if.slave  bus
);

  localparam logic [PULSE_CNT_W-1:0] PULSE_LAST = PULSE_CNT_W'(PULSE_CYCLES - 1);

  logic set_level;
  logic clr_level;
  logic set_rise;
  logic clr_rise;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (bus.set_btn),
    .level   (set_level),
    .rise    (set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (bus.clr_btn),
    .level   (clr_level),
    .rise    (clr_rise)
  );

  state_t                 state;
  state_t                 state_nxt;
  logic [PULSE_CNT_W-1:0] pcnt;
  logic [PULSE_CNT_W-1:0] pcnt_nxt;
  logic                   pend_set;
  logic                   pend_clr;
  logic                   take_set;
  logic                   take_clr;
  logic                   s_q;
  logic                   r_q;

  // Leaving a pulse state always lands in IDLE, which guarantees the
  // one-cycle s=r=0 gap before the next pulse.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    take_set  = 1'b0;
    take_clr  = 1'b0;
    case (state)
      IDLE: begin
        pcnt_nxt = '0;
        if (pend_clr) begin
          state_nxt = CLR_PULSE;
          take_clr  = 1'b1;
        end else if (pend_set) begin
          state_nxt = SET_PULSE;
          take_set  = 1'b1;
        end
      end
      SET_PULSE, CLR_PULSE: begin
        if (pcnt == PULSE_LAST) begin
          state_nxt = IDLE;
          pcnt_nxt  = '0;
        end else begin
          pcnt_nxt = pcnt + PULSE_CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        pcnt_nxt  = '0;
      end
    endcase
  end

  // s/r are decoded from the next state and registered so they align with
  // the state register and never glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      pend_set <= 1'b0;
      pend_clr <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pcnt     <= pcnt_nxt;
      // A fresh edge in the same cycle a request is served stays pending.
      pend_set <= set_rise | (pend_set & ~take_set);
      pend_clr <= clr_rise | (pend_clr & ~take_clr);
      s_q      <= (state_nxt == SET_PULSE);
      r_q      <= (state_nxt == CLR_PULSE);
    end
  end

  assign bus.s    = s_q;
  assign bus.r    = r_q;
  assign bus.busy = (state != IDLE) | pend_set | pend_clr;

`ifdef SR_EVENT_CNT_EN
  logic [EVT_CNT_W-1:0] evt_cnt;

  // Counts on the edge that starts each pulse; holds at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      evt_cnt <= '0;
    end else if ((take_set | take_clr) && (evt_cnt != {EVT_CNT_W{1'b1}})) begin
      evt_cnt <= evt_cnt + EVT_CNT_W'(1);
    end
  end

  assign bus.event_count = evt_cnt;
`endif

  // Levels are only consumed through their rise strobes.
  logic unused_levels;
  assign unused_levels = set_level ^ clr_level;

endmodule

// File: tb/tb_sr_input_conditioner.sv
module tb_sr_input_conditioner;

  logic clock;
  logic reset_n;
  logic q;
  int   total;
  int   bad;

  sr_input_conditioner_if ifa ();
  sr_input_conditioner_if ifb ();

  sr_input_conditioner u_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  sr_input_conditioner #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3)) u_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Downstream SR flip-flop fed by the default-parameter instance.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)   q <= 1'b0;
    else if (ifa.s) q <= 1'b1;
    else if (ifa.r) q <= 1'b0;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    ifa.set_btn = 1'b0;
    ifa.clr_btn = 1'b0;
    ifb.set_btn = 1'b0;
    ifb.clr_btn = 1'b0;
    tick();
    tick();
    total++; if (ifa.s !== 1'b0)    begin bad++; $display("FAIL reset_a_s got=%b want=0", ifa.s); end
    total++; if (ifa.r !== 1'b0)    begin bad++; $display("FAIL reset_a_r got=%b want=0", ifa.r); end
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL reset_a_busy got=%b want=0", ifa.busy); end
    total++; if (ifb.s !== 1'b0)    begin bad++; $display("FAIL reset_b_s got=%b want=0", ifb.s); end
    total++; if (ifb.r !== 1'b0)    begin bad++; $display("FAIL reset_b_r got=%b want=0", ifb.r); end
    total++; if (ifb.busy !== 1'b0) begin bad++; $display("FAIL reset_b_busy got=%b want=0", ifb.busy); end
    total++; if (q !== 1'b0)        begin bad++; $display("FAIL reset_q got=%b want=0", q); end
`ifdef SR_EVENT_CNT_EN
    total++; if (ifa.event_count !== 8'd0) begin bad++; $display("FAIL reset_evt got=%0d want=0", ifa.event_count); end
`endif
    reset_n = 1'b1;
  endtask

  // Button held through reset release: one s pulse 7 edges after first sample.
  task automatic test_latency();
    logic exp_s;
    logic exp_busy;
    ifa.set_btn = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_s    = (i == 7);
      exp_busy = (i == 6) || (i == 7);
      total++; if (ifa.s !== exp_s)       begin bad++; $display("FAIL latency_s i=%0d got=%b want=%b", i, ifa.s, exp_s); end
      total++; if (ifa.r !== 1'b0)        begin bad++; $display("FAIL latency_r i=%0d got=%b want=0", i, ifa.r); end
      total++; if (ifa.busy !== exp_busy) begin bad++; $display("FAIL latency_busy i=%0d got=%b want=%b", i, ifa.busy, exp_busy); end
    end
    total++; if (q !== 1'b1) begin bad++; $display("FAIL latency_q got=%b want=1", q); end
    ifa.set_btn = 1'b0;
  endtask

  // Input toggling every cycle never settles long enough to be accepted.
  task automatic test_glitch();
    ifa.set_btn = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 35; i++) begin
      ifa.set_btn = (i < 20) ? ((i % 2) == 0) : 1'b0;
      tick();
      total++; if (ifa.s !== 1'b0)    begin bad++; $display("FAIL glitch_s i=%0d got=%b want=0", i, ifa.s); end
      total++; if (ifa.r !== 1'b0)    begin bad++; $display("FAIL glitch_r i=%0d got=%b want=0", i, ifa.r); end
      total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL glitch_busy i=%0d got=%b want=0", i, ifa.busy); end
    end
  endtask

  // Both buttons together: r first, one idle cycle, then s.
  task automatic test_simultaneous();
    logic exp_s;
    logic exp_r;
    ifa.set_btn = 1'b0;
    ifa.clr_btn = 1'b0;
    do_reset();
    tick();
    tick();
    ifa.set_btn = 1'b1;
    ifa.clr_btn = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      exp_r = (i == 7);
      exp_s = (i == 9);
      total++; if (ifa.r !== exp_r) begin bad++; $display("FAIL simul_r i=%0d got=%b want=%b", i, ifa.r, exp_r); end
      total++; if (ifa.s !== exp_s) begin bad++; $display("FAIL simul_s i=%0d got=%b want=%b", i, ifa.s, exp_s); end
      total++; if ((ifa.s & ifa.r) !== 1'b0) begin bad++; $display("FAIL simul_excl i=%0d got=%b want=0", i, ifa.s & ifa.r); end
    end
    total++; if (q !== 1'b1) begin bad++; $display("FAIL simul_q got=%b want=1", q); end
    ifa.set_btn = 1'b0;
    ifa.clr_btn = 1'b0;
  endtask

  // 3-cycle pulses: clear edge lands during the s pulse and is served after the gap.
  task automatic test_back_to_back();
    logic exp_s;
    logic exp_r;
    logic exp_busy;
    ifb.set_btn = 1'b0;
    ifb.clr_btn = 1'b0;
    do_reset();
    tick();
    ifb.set_btn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 2) ifb.clr_btn = 1'b1;
      tick();
      exp_s    = (i >= 7)  && (i <= 9);
      exp_r    = (i >= 11) && (i <= 13);
      exp_busy = (i >= 6)  && (i <= 13);
      total++; if (ifb.s !== exp_s)       begin bad++; $display("FAIL b2b_s i=%0d got=%b want=%b", i, ifb.s, exp_s); end
      total++; if (ifb.r !== exp_r)       begin bad++; $display("FAIL b2b_r i=%0d got=%b want=%b", i, ifb.r, exp_r); end
      total++; if (ifb.busy !== exp_busy) begin bad++; $display("FAIL b2b_busy i=%0d got=%b want=%b", i, ifb.busy, exp_busy); end
    end
    ifb.set_btn = 1'b0;
    ifb.clr_btn = 1'b0;
  endtask

  // Reset in the second cycle of a 3-cycle s pulse cuts it immediately.
  task automatic test_reset_mid_pulse();
    ifb.set_btn = 1'b0;
    ifb.clr_btn = 1'b0;
    do_reset();
    tick();
    ifb.set_btn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i >= 7) begin
        total++; if (ifb.s !== 1'b1) begin bad++; $display("FAIL midrst_pre_s i=%0d got=%b want=1", i, ifb.s); end
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (ifb.s !== 1'b0)    begin bad++; $display("FAIL midrst_s got=%b want=0", ifb.s); end
    total++; if (ifb.r !== 1'b0)    begin bad++; $display("FAIL midrst_r got=%b want=0", ifb.r); end
    total++; if (ifb.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", ifb.busy); end
    ifb.set_btn = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if ((ifb.s | ifb.r | ifb.busy) !== 1'b0) begin bad++; $display("FAIL midrst_after i=%0d got=%b want=0", i, ifb.s | ifb.r | ifb.busy); end
    end
  endtask

`ifdef SR_EVENT_CNT_EN
  task automatic test_event_count();
    ifa.set_btn = 1'b0;
    ifa.clr_btn = 1'b0;
    do_reset();
    tick();
    for (int p = 0; p < 300; p++) begin
      ifa.set_btn = 1'b1;
      repeat (8) tick();
      ifa.set_btn = 1'b0;
      repeat (8) tick();
      if (p == 9) begin
        total++; if (ifa.event_count !== 8'd10) begin bad++; $display("FAIL evt_10 got=%0d want=10", ifa.event_count); end
      end
      if (p == 254) begin
        total++; if (ifa.event_count !== 8'd255) begin bad++; $display("FAIL evt_255 got=%0d want=255", ifa.event_count); end
      end
    end
    total++; if (ifa.event_count !== 8'd255) begin bad++; $display("FAIL evt_sat got=%0d want=255", ifa.event_count); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_pulse();
`ifdef SR_EVENT_CNT_EN
    test_event_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
